cordic_req_arbiter: RTL and testbench

//  Shares one CORDIC sin/cos engine (FP32 in -> FP32 out, start/done handshake) between N_REQ

---
 rtl/cordic_req_arbiter.sv | 177 +++++++++++++++++
 tb/tb_cordic_req_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cordic_req_arbiter
// Description : Round-robin front end that shares one CORDIC sin/cos engine
//               between N_REQ requesters, with a hang watchdog.
// Revision    : 1.0  initial release
// ============================================================================
module cordic_req_arbiter #(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ-1:0]    req_cos,
    input  logic [32*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [31:0]         rsp_result,
    output logic                rsp_invalid,
    output logic                rsp_timeout,
    output logic                busy,
    output logic [31:0]         eng_dataa,
    output logic                eng_cos,
    output logic                eng_start,
    input  logic                eng_done,
    input  logic [31:0]         eng_result,
    input  logic                eng_invalid
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYC);

    localparam logic [WD_W-1:0]  c_wd_last  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(N_REQ - 1);
    localparam logic [PTR_W:0]   c_n_req    = (PTR_W+1)'(N_REQ);
    localparam logic [N_REQ-1:0] c_one      = N_REQ'(1);
    localparam logic [31:0]      c_qnan     = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_gnt;
    logic [31:0]        r_dataa;
    logic               r_cos;
    logic [WD_W-1:0]    r_wd;

    logic               w_any;
    logic [PTR_W-1:0]   w_grant;
    logic [PTR_W:0]     w_idx;
    logic [N_REQ-1:0]   w_gnt_oh;

    // Round-robin pick: first pending requester at or above r_ptr, wrapping.
    always_comb begin
        w_any   = 1'b0;
        w_grant = r_ptr;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_idx >= c_n_req) begin
                w_idx = w_idx - c_n_req;
            end
            if (!w_any && req_valid[w_idx[PTR_W-1:0]]) begin
                w_any   = 1'b1;
                w_grant = w_idx[PTR_W-1:0];
            end
        end
    end

    assign w_gnt_oh = c_one << r_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else if (clk_en) begin
            r_state <= w_state_nxt;
        end
    end

    // Pulses decode from the state, so a frozen FSM also freezes them.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        rsp_valid   = '0;
        eng_start   = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                req_ready = w_gnt_oh;
                if (eng_invalid) begin
                    w_state_nxt = S_RESP;
                end else begin
                    eng_start   = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (eng_done || (r_wd == c_wd_last)) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid   = w_gnt_oh;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_dataa     <= '0;
            r_cos       <= 1'b0;
            r_wd        <= '0;
            rsp_result  <= '0;
            rsp_invalid <= 1'b0;
            rsp_timeout <= 1'b0;
        end else if (clk_en) begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_grant;
                        r_dataa <= req_data[32*w_grant +: 32];
                        r_cos   <= req_cos[w_grant];
                        r_ptr   <= (w_grant == c_ptr_last) ? '0 : w_grant + 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (eng_invalid) begin
                        rsp_result  <= c_qnan;
                        rsp_invalid <= 1'b1;
                        rsp_timeout <= 1'b0;
                    end else begin
                        r_wd <= '0;
                    end
                end
                S_WAIT: begin
                    r_wd <= r_wd + 1'b1;
                    // A completion in the expiry cycle still delivers the real result.
                    if (eng_done) begin
                        rsp_result  <= eng_result;
                        rsp_invalid <= 1'b0;
                        rsp_timeout <= 1'b0;
                    end else if (r_wd == c_wd_last) begin
                        rsp_result  <= '0;
                        rsp_invalid <= 1'b0;
                        rsp_timeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign eng_dataa = r_dataa;
    assign eng_cos   = r_cos;

endmodule
`default_nettype wire

// File: tb/tb_cordic_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_req_arbiter
// Description : Directed self-checking bench with a behavioural CORDIC engine.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cordic_req_arbiter;

    localparam int          N       = 2;
    localparam logic [31:0] c_inf   = 32'h7F80_0000;
    localparam logic [31:0] c_qnan  = 32'h7FC0_0000;

    logic           clk;
    logic           reset;
    logic           clk_en;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_cos;
    logic [32*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [31:0]    rsp_result;
    logic           rsp_invalid;
    logic           rsp_timeout;
    logic           busy;
    logic [31:0]    eng_dataa;
    logic           eng_cos;
    logic           eng_start;
    logic           eng_done   = 1'b0;
    logic [31:0]    eng_result = 32'h0;
    logic           eng_invalid;

    // Second instance with a short watchdog, driven by the same stimulus.
    logic [N-1:0]   rdy_b;
    logic [N-1:0]   rv_b;
    logic [31:0]    res_b;
    logic           inv_b;
    logic           to_b;
    logic           busy_b;
    logic [31:0]    dataa_b;
    logic           cos_b;
    logic           start_b;
    logic           eng_invalid_b;

    int n_tests = 0;
    int n_fail  = 0;
    int n_start = 0;
    int eng_lat = 20;
    int eng_cnt = 0;
    logic [31:0] m_data = 32'h0;
    logic        m_cos  = 1'b0;

    assign eng_invalid   = (eng_dataa == c_inf);
    assign eng_invalid_b = (dataa_b == c_inf);

    cordic_req_arbiter #(.N_REQ(N), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .req_valid(req_valid), .req_cos(req_cos), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .rsp_invalid(rsp_invalid), .rsp_timeout(rsp_timeout), .busy(busy),
        .eng_dataa(eng_dataa), .eng_cos(eng_cos), .eng_start(eng_start),
        .eng_done(eng_done), .eng_result(eng_result), .eng_invalid(eng_invalid)
    );

    cordic_req_arbiter #(.N_REQ(N), .TIMEOUT_CYC(16)) dut_wd (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .req_valid(req_valid), .req_cos(req_cos), .req_data(req_data),
        .req_ready(rdy_b), .rsp_valid(rv_b), .rsp_result(res_b),
        .rsp_invalid(inv_b), .rsp_timeout(to_b), .busy(busy_b),
        .eng_dataa(dataa_b), .eng_cos(cos_b), .eng_start(start_b),
        .eng_done(eng_done), .eng_result(eng_result), .eng_invalid(eng_invalid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] eng_ref(input logic [31:0] d, input logic c);
        if (d == 32'h0) return c ? 32'h3F80_0000 : 32'h0;
        return {c, d[30:0]} ^ 32'h0055_AA00;
    endfunction

    function automatic logic [31:0] t2_data(input int g, input int op);
        return 32'h3F00_0001 | (32'(g) << 12) | (32'(op) << 4);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Engine model: samples at negedge+1, answers after eng_lat enabled cycles.
    initial begin : eng_model
        logic m_en, m_st, m_rs;
        forever begin
            @(negedge clk); #1;
            m_en = clk_en;
            m_st = eng_start;
            m_rs = reset;
            if (eng_start) begin
                m_data = eng_dataa;
                m_cos  = eng_cos;
            end
            @(posedge clk); #1;
            if (m_rs) begin
                eng_done = 1'b0;
                eng_cnt  = 0;
            end else if (m_en) begin
                eng_done = 1'b0;
                if (eng_cnt > 0) begin
                    eng_cnt--;
                    if (eng_cnt == 0) begin
                        eng_done   = 1'b1;
                        eng_result = eng_ref(m_data, m_cos);
                    end
                end
                if (m_st) begin
                    n_start++;
                    eng_cnt = eng_lat - 1;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        clk_en    = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_one(input int idx, input logic [31:0] data, input logic c,
                           input bit toggle, input int max_cyc,
                           output int lat, output int rdy_n, output int st_n);
        lat   = 0;
        rdy_n = 0;
        st_n  = 0;
        @(negedge clk);
        req_data[32*idx +: 32] = data;
        req_cos[idx]           = c;
        req_valid[idx]         = 1'b1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            if (req_ready[idx]) begin
                rdy_n++;
                req_valid[idx] = 1'b0;
            end
            if (eng_start) st_n++;
            if (rsp_valid != '0) begin
                lat = k;
                break;
            end
            if (toggle) clk_en = ~clk_en;
        end
        req_valid[idx] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x%08h expected 0x%08h", 1, 0);
        $fatal(1, "bench timeout");
    end

    initial begin
        int lat, rdy_n, st_n, s0, g, ngr, nrsp, cur_g, cur_op, extra, found;
        int op_idx[N];
        reset     = 1'b1;
        clk_en    = 1'b1;
        req_valid = '0;
        req_cos   = '0;
        req_data  = '0;
        do_reset();

        // Reset state
        check_val("rst_busy",  busy,        0);
        check_val("rst_ready", req_ready,   0);
        check_val("rst_rsp",   rsp_valid,   0);
        check_val("rst_res",   rsp_result,  0);
        check_val("rst_flags", {rsp_invalid, rsp_timeout, eng_start, eng_cos}, 0);
        check_val("rst_dataa", eng_dataa,   0);

        // Test 1: cos(0) with 20-cycle engine latency
        eng_lat = 20;
        s0 = n_start;
        run_one(0, 32'h0, 1'b1, 1'b0, 100, lat, rdy_n, st_n);
        check_val("t1_lat",     lat,         22);
        check_val("t1_rdy_n",   rdy_n,       1);
        check_val("t1_start_n", n_start - s0, 1);
        check_val("t1_rsp_sel", rsp_valid,   2'b01);
        check_val("t1_result",  rsp_result,  32'h3F80_0000);
        check_val("t1_flags",   {rsp_invalid, rsp_timeout}, 0);
        @(negedge clk);
        check_val("t1_rsp_pulse", rsp_valid, 0);
        check_val("t1_idle",    busy,        0);

        // Test 2: both requesters continuously valid, 4 ops each
        do_reset();
        eng_lat = 5;
        for (int i = 0; i < N; i++) begin
            op_idx[i]            = 0;
            req_data[32*i +: 32] = t2_data(i, 0);
            req_cos[i]           = 1'(i);
        end
        req_valid = 2'b11;
        ngr = 0; nrsp = 0; cur_g = 0; cur_op = 0;
        for (int c = 0; c < 400 && nrsp < 8; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                check_val("t2_rsp_sel",  rsp_valid, 2'b01 << cur_g);
                check_val("t2_rsp_data", rsp_result,
                          eng_ref(t2_data(cur_g, cur_op), 1'((cur_g ^ cur_op) & 1)));
                nrsp++;
            end
            if (req_ready != '0) begin
                g = req_ready[1] ? 1 : 0;
                check_val("t2_grant", g, ngr % 2);
                cur_g  = g;
                cur_op = op_idx[g];
                op_idx[g]++;
                ngr++;
                if (op_idx[g] == 4) begin
                    req_valid[g] = 1'b0;
                end else begin
                    req_data[32*g +: 32] = t2_data(g, op_idx[g]);
                    req_cos[g]           = 1'((g ^ op_idx[g]) & 1);
                end
            end
        end
        check_val("t2_nrsp", nrsp, 8);

        // Test 3: infinite input is rejected without starting the engine
        do_reset();
        s0 = n_start;
        run_one(0, c_inf, 1'b0, 1'b0, 20, lat, rdy_n, st_n);
        check_val("t3_lat",     lat,          2);
        check_val("t3_rdy_n",   rdy_n,        1);
        check_val("t3_start_n", n_start - s0, 0);
        check_val("t3_rsp_sel", rsp_valid,    2'b01);
        check_val("t3_result",  rsp_result,   c_qnan);
        check_val("t3_invalid", rsp_invalid,  1);
        check_val("t3_timeout", rsp_timeout,  0);

        // Test 4: watchdog on the 16-cycle instance, engine answers only at 40
        do_reset();
        eng_lat = 40;
        @(negedge clk);
        req_data[31:0] = 32'h4049_0FDB;
        req_cos[0]     = 1'b0;
        req_valid[0]   = 1'b1;
        found = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rdy_b[0]) begin
                found = 1;
                break;
            end
        end
        req_valid[0] = 1'b0;
        check_val("t4_ready", found, 1);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rv_b != '0) begin
                lat = k;
                break;
            end
        end
        check_val("t4_lat",     lat,   17);
        check_val("t4_rsp_sel", rv_b,  2'b01);
        check_val("t4_result",  res_b, 0);
        check_val("t4_timeout", to_b,  1);
        check_val("t4_invalid", inv_b, 0);
        extra = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rv_b != '0) extra++;
        end
        check_val("t4_late_rsp",  extra, 0);
        check_val("t4_late_res",  res_b, 0);
        check_val("t4_late_to",   to_b,  1);
        check_val("t4_late_busy", busy_b, 0);
        check_val("t4_long_wd_res", rsp_result, eng_ref(32'h4049_0FDB, 1'b0));
        check_val("t4_long_wd_to",  rsp_timeout, 0);

        // Test 5a: clk_en toggling every cycle
        do_reset();
        eng_lat = 6;
        s0 = n_start;
        run_one(0, 32'h3F00_0000, 1'b0, 1'b1, 100, lat, rdy_n, st_n);
        check_val("t5_found",    (lat != 0), 1);
        check_val("t5_rdy_hold", rdy_n, 2);
        check_val("t5_st_hold",  st_n,  2);
        check_val("t5_start_n",  n_start - s0, 1);
        check_val("t5_rsp_sel",  rsp_valid,  2'b01);
        check_val("t5_result",   rsp_result, eng_ref(32'h3F00_0000, 1'b0));
        clk_en = 1'b0;
        @(negedge clk);
        check_val("t5_rsp_hold", rsp_valid,  2'b01);
        clk_en = 1'b1;
        @(negedge clk);
        check_val("t5_rsp_end",  rsp_valid,  0);

        // Test 5b: reset while waiting on the engine
        eng_lat = 10;
        @(negedge clk);
        req_data[31:0] = 32'h3E00_0000;
        req_cos[0]     = 1'b1;
        req_valid[0]   = 1'b1;
        found = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready[0]) begin
                found = 1;
                break;
            end
        end
        req_valid[0] = 1'b0;
        check_val("t5_rst_ready", found, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("t5_rst_busy",  busy,       0);
        check_val("t5_rst_res",   rsp_result, 0);
        check_val("t5_rst_dataa", eng_dataa,  0);
        check_val("t5_rst_outs",  {req_ready, rsp_valid, eng_start, eng_cos}, 0);
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) extra++;
        end
        check_val("t5_rst_norsp", extra, 0);
        run_one(1, 32'h3F40_0000, 1'b0, 1'b0, 100, lat, rdy_n, st_n);
        check_val("t5_post_lat", lat,        12);
        check_val("t5_post_sel", rsp_valid,  2'b10);
        check_val("t5_post_res", rsp_result, eng_ref(32'h3F40_0000, 1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
